wb_cmd_master: RTL and testbench

//   Wishbone classic initiator: converts single commands from a valid/ready

---
 rtl/wb_cmd_master.sv | 113 +++++++++++
 tb/tb_wb_cmd_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Wishbone classic initiator. Takes one command at a time from a valid/ready
//   command port, runs a single Wishbone read or write cycle, and returns the
//   result on a valid/ready response port. A strobe that goes unacknowledged
//   for TIMEOUT_CYCLES cycles ends the cycle and reports an error.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i command fields (data ignored for reads)
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_dat_o, rsp_err_o          read data (0 for writes/errors), timeout flag
//   cyc_o, stb_o, we_o, adr_o, dat_o, dat_i, ack_i   Wishbone classic bus
//   busy_o                        high whenever a command is in progress
module wb_cmd_master #(
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned WB_ADDR_WIDTH  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] cmd_dat_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0] rsp_dat_o,
  output logic                     rsp_err_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  output logic                     busy_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Ready is gated by reset so no command can be taken while state is forced.
  assign cmd_ready_o = (state == IDLE) && !rst_i;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            state <= BUS;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= cmd_we_i;
            adr_o <= cmd_adr_i;
            dat_o <= cmd_we_i ? cmd_dat_i : '0;
            cnt   <= '0;
          end
        end
        BUS: begin
          // Ack is tested first so an ack in the final strobe cycle beats the timeout.
          if (ack_i) begin
            rsp_dat_o   <= we_o ? '0 : dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            state       <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master
//   Self-checking bench for wb_cmd_master with a behavioural Wishbone
//   responder whose ack position, read data and stale-ack behaviour are set
//   per command. Expected results are queued at command acceptance and
//   compared when the bus cycle and response appear.
module tb_wb_cmd_master;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_we_i = 1'b0;
  logic [1:0] cmd_adr_i = '0;
  logic [7:0] cmd_dat_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b1;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;
  logic       cyc_o;
  logic       stb_o;
  logic       we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;
  logic       busy_o;

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [7:0]  dato;
    logic [7:0]  rdat;
    logic        err;
    int unsigned len;
  } exp_t;

  exp_t q[$];

  int          checks   = 0;
  int          failures = 0;
  int unsigned ack_at   = 0;
  logic [7:0]  rd_data  = '0;
  logic        stale_en = 1'b0;
  int unsigned stb_len  = 0;
  int unsigned last_len = 0;
  int unsigned gap      = 100;

  wb_cmd_master #(
    .WB_DATA_WIDTH (8),
    .WB_ADDR_WIDTH (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Responder: acks from strobe cycle ack_at onwards (0 = never); optionally
  // keeps ack high for one cycle after the strobe drops.
  initial begin : responder
    int unsigned stb_n;
    logic        pend;
    stb_n = 0;
    pend  = 1'b0;
    ack_i = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk);
      dat_i = rd_data;
      if (rst_i) begin
        stb_n = 0;
        pend  = 1'b0;
        ack_i = 1'b0;
      end else if (stb_o) begin
        stb_n++;
        ack_i = (ack_at != 0) && (stb_n >= ack_at);
        pend  = ack_i;
      end else begin
        ack_i = stale_en && pend;
        pend  = 1'b0;
        stb_n = 0;
      end
    end
  end

  // Bus and response monitor / scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        stb_len = 0;
      end else begin
        if (stb_o) begin
          if (stb_len == 0)
            check_eq("cyc_gap_ge2", 32'(gap >= 2), 32'd1);
          check_eq("cyc_with_stb", 32'(cyc_o), 32'd1);
          if (q.size() == 0) begin
            check_eq("stb_without_cmd", 32'(q.size()), 32'd1);
          end else begin
            check_eq("we_o", 32'(we_o), 32'(q[0].we));
            check_eq("adr_o", 32'(adr_o), 32'(q[0].adr));
            check_eq("dat_o", 32'(dat_o), 32'(q[0].dato));
          end
          stb_len++;
        end else if (stb_len != 0) begin
          last_len = stb_len;
          stb_len  = 0;
          check_eq("rsp_after_bus", 32'(rsp_valid_o), 32'd1);
        end
        if (rsp_valid_o && rsp_ready_i) begin
          if (q.size() == 0) begin
            check_eq("rsp_without_cmd", 32'(q.size()), 32'd1);
          end else begin
            e = q.pop_front();
            check_eq("rsp_dat", 32'(rsp_dat_o), 32'(e.rdat));
            check_eq("rsp_err", 32'(rsp_err_o), 32'(e.err));
            check_eq("stb_len", last_len, e.len);
          end
        end
      end
      if (cyc_o) gap = 0;
      else       gap++;
    end
  end

  task automatic do_cmd(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                        input logic [7:0] rdat, input int unsigned ackat);
    exp_t        e;
    int unsigned n;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      check_eq("cmd_accept_timeout", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    e.we   = we;
    e.adr  = adr;
    e.dato = we ? dat : 8'h00;
    e.err  = (ackat == 0) || (ackat > 16);
    e.rdat = (we || e.err) ? 8'h00 : rdat;
    e.len  = e.err ? 16 : ackat;
    q.push_back(e);
    #1;
    cmd_valid_i = 1'b0;
    rd_data     = rdat;
    ack_at      = ackat;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while ((busy_o || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_in_time", 32'(busy_o || q.size() != 0), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int unsigned n;
    #1 rst_i = 1'b1;
    #2;
    check_eq("rst_cyc", 32'(cyc_o), 32'd0);
    check_eq("rst_stb", 32'(stb_o), 32'd0);
    check_eq("rst_we", 32'(we_o), 32'd0);
    check_eq("rst_adr", 32'(adr_o), 32'd0);
    check_eq("rst_dat", 32'(dat_o), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rsp_dat", 32'(rsp_dat_o), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Write, ack in second strobe cycle; read data on the bus must not leak.
    do_cmd(1'b1, 2'd2, 8'hA5, 8'h77, 2);
    wait_done();

    // Read with stale ack after the strobe drops.
    stale_en = 1'b1;
    do_cmd(1'b0, 2'd1, 8'h5A, 8'h3C, 2);
    wait_done();
    repeat (3) begin
      @(negedge clk);
      check_eq("stale_cyc", 32'(cyc_o), 32'd0);
      check_eq("stale_busy", 32'(busy_o), 32'd0);
      check_eq("rsp_dat_hold", 32'(rsp_dat_o), 32'h3C);
    end
    stale_en = 1'b0;

    // Timeout, then ack landing in the final strobe cycle.
    do_cmd(1'b0, 2'd0, 8'h00, 8'hEE, 0);
    wait_done();
    do_cmd(1'b0, 2'd3, 8'h00, 8'hC3, 16);
    wait_done();

    // Response back-pressure, then back-to-back commands.
    rsp_ready_i = 1'b0;
    do_cmd(1'b0, 2'd2, 8'h11, 8'h96, 3);
    n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid_o), 32'd1);
      check_eq("hold_dat", 32'(rsp_dat_o), 32'h96);
      check_eq("hold_err", 32'(rsp_err_o), 32'd0);
      check_eq("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
      check_eq("hold_busy", 32'(busy_o), 32'd1);
    end
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++)
      do_cmd(i[0], 2'(i), 8'(8'h10 * i + 3), 8'(8'hC0 + i), 32'(i + 1));
    wait_done();

    // Reset in the middle of a bus cycle.
    do_cmd(1'b1, 2'd1, 8'h42, 8'h00, 0);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_stb", 32'(stb_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("mid_rst_cyc", 32'(cyc_o), 32'd0);
    check_eq("mid_rst_stb", 32'(stb_o), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    q.delete();
    @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    check_eq("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check_eq("post_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
      check_eq("post_rst_cyc", 32'(cyc_o), 32'd0);
    end
    do_cmd(1'b0, 2'd3, 8'h00, 8'h5E, 2);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
